seq_mult_taint_core: RTL and testbench

- Self-contained, parametrised shift-add sequential multiplier with an integrated controller FSM and bit-level taint (information-flow) tracking on every datapath register.
- Successor to the split controller/datapath taint-tracked multiplier. Adds:
  - start/busy/done handshake;
  - early termination;
  - timing-taint output;
  - selectable precise or conservative taint propagation.
- Sits between operand sources and any consumer that must know which product bits depend on tainted inputs.

---
 rtl/seq_mult_taint_core.sv | 128 ++++++++++++
 tb/tb_seq_mult_taint_core.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_taint_core.sv
// Shift-add sequential multiplier with a start/busy/done handshake and bit-level
// taint tracking on every datapath register, including a taint on completion timing.
module seq_mult_taint_core #(
  parameter int WIDTH      = 4,
  parameter int EARLY_EXIT = 1,
  parameter int PRECISE    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 start_t,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplicand_t,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplier_t,
  output logic                 busy,
  output logic                 done,
  output logic                 done_t,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   product_t
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     acc_reg, acc_t_reg, mcand_reg, mcand_t_reg;
  logic [WIDTH-1:0]  mplier_reg, mplier_t_reg;
  logic [CW-1:0]     cnt_reg;
  logic              ctl_t_reg, bt_any_reg;
  logic [PW-1:0]     product_reg, product_t_reg;
  logic              done_t_reg;

  logic              accept, add_maybe, last_iter;
  logic [PW-1:0]     acc_add, acc_t_add, spread_src, spread_mask;
  logic [WIDTH-1:0]  mplier_sh, mplier_t_sh;

  assign accept    = start && (state_reg == IDLE || state_reg == DONE);
  assign add_maybe = mplier_reg[0] | mplier_t_reg[0];
  assign mplier_sh   = mplier_reg >> 1;
  assign mplier_t_sh = mplier_t_reg >> 1;
  assign last_iter = (cnt_reg == CW'(WIDTH - 1)) ||
                     ((EARLY_EXIT != 0) && (mplier_sh == '0) && (mplier_t_sh == '0));

  // x | -x sets every bit at or above the lowest set bit of x: the reach of a carry.
  always_comb begin
    acc_add     = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
    spread_src  = '0;
    if (mplier_t_reg[0])
      spread_src = mcand_reg | mcand_t_reg | acc_t_reg;
    else if (mplier_reg[0])
      spread_src = acc_t_reg | mcand_t_reg;
    spread_mask = spread_src | (~spread_src + PW'(1));
    if (PRECISE != 0)
      acc_t_add = acc_t_reg | spread_mask;
    else if (add_maybe && ((|acc_t_reg) || (|mcand_t_reg) || mplier_t_reg[0]))
      acc_t_add = '1;
    else
      acc_t_add = acc_t_reg;
    if (ctl_t_reg && add_maybe)
      acc_t_add = '1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      acc_t_reg     <= '0;
      mcand_reg     <= '0;
      mcand_t_reg   <= '0;
      mplier_reg    <= '0;
      mplier_t_reg  <= '0;
      cnt_reg       <= '0;
      ctl_t_reg     <= 1'b0;
      bt_any_reg    <= 1'b0;
      product_reg   <= '0;
      product_t_reg <= '0;
      done_t_reg    <= 1'b0;
    end else if (accept) begin
      acc_reg      <= '0;
      acc_t_reg    <= '0;
      mcand_reg    <= {{WIDTH{1'b0}}, multiplicand};
      mcand_t_reg  <= {{WIDTH{1'b0}}, multiplicand_t};
      mplier_reg   <= multiplier;
      mplier_t_reg <= multiplier_t;
      cnt_reg      <= '0;
      ctl_t_reg    <= start_t;
      bt_any_reg   <= |multiplier_t;
    end else if (state_reg == RUN) begin
      acc_reg      <= acc_add;
      acc_t_reg    <= acc_t_add;
      mcand_reg    <= mcand_reg << 1;
      mcand_t_reg  <= mcand_t_reg << 1;
      mplier_reg   <= mplier_sh;
      mplier_t_reg <= mplier_t_sh;
      cnt_reg      <= cnt_reg + CW'(1);
      if (last_iter) begin
        product_reg   <= acc_add;
        product_t_reg <= ctl_t_reg ? '1 : acc_t_add;
        // Early exit makes the finishing time depend on the multiplier's taint.
        done_t_reg    <= ctl_t_reg | ((EARLY_EXIT != 0) & bt_any_reg);
      end
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign done_t    = done_t_reg;
  assign product   = product_reg;
  assign product_t = product_t_reg;

endmodule

// File: tb/tb_seq_mult_taint_core.sv
// Directed bench: three multiplier configurations share stimulus; each vector is
// checked on one selected instance for latency, product and taint outputs.
module tb_seq_mult_taint_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start_t = 1'b0;
  logic [3:0] a = '0, at = '0, b = '0, bt = '0;

  logic [2:0] busy_w, done_w, done_t_w;
  logic [7:0] prod_w   [3];
  logic [7:0] prod_t_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: EARLY_EXIT=0 PRECISE=1, 1: EARLY_EXIT=1 PRECISE=1, 2: EARLY_EXIT=1 PRECISE=0
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      seq_mult_taint_core #(
        .WIDTH(4), .EARLY_EXIT(gi == 0 ? 0 : 1), .PRECISE(gi == 2 ? 0 : 1)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplicand(a), .multiplicand_t(at), .multiplier(b), .multiplier_t(bt),
        .busy(busy_w[gi]), .done(done_w[gi]), .done_t(done_t_w[gi]),
        .product(prod_w[gi]), .product_t(prod_t_w[gi])
      );
    end
  endgenerate

  typedef struct {
    int         sel;
    logic [3:0] a, at, b, bt;
    logic       st;
    logic [7:0] p, pt;
    logic       dt;
    int         lat;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int sel, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=0x%0h required=0x%0h", name, sel, act, exp);
    end
  endtask

  task automatic wait_done(input int sel, output int k, output int bc);
    k = 0;
    bc = 0;
    while (!done_w[sel] && k < 20) begin
      if (busy_w[sel]) bc++;
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  initial begin
    int k, bc, k2, bc2;
    vecs[0]  = '{0, 4'd13, 4'h0, 4'd11, 4'h0, 1'b0, 8'h8F, 8'h00, 1'b0, 4};
    vecs[1]  = '{1, 4'd5,  4'h0, 4'd2,  4'h0, 1'b0, 8'd10, 8'h00, 1'b0, 2};
    vecs[2]  = '{1, 4'd5,  4'h4, 4'd1,  4'h0, 1'b0, 8'd5,  8'hFC, 1'b0, 1};
    vecs[3]  = '{0, 4'd5,  4'h4, 4'd1,  4'h0, 1'b0, 8'd5,  8'hFC, 1'b0, 4};
    vecs[4]  = '{2, 4'd5,  4'h4, 4'd1,  4'h0, 1'b0, 8'd5,  8'hFF, 1'b0, 1};
    vecs[5]  = '{2, 4'd5,  4'h0, 4'd0,  4'h2, 1'b0, 8'd0,  8'hFF, 1'b1, 2};
    vecs[6]  = '{1, 4'd5,  4'h0, 4'd0,  4'h2, 1'b0, 8'd0,  8'hFE, 1'b1, 2};
    vecs[7]  = '{0, 4'd3,  4'h0, 4'd3,  4'h0, 1'b1, 8'd9,  8'hFF, 1'b1, 4};
    vecs[8]  = '{1, 4'd3,  4'h0, 4'd3,  4'h0, 1'b1, 8'd9,  8'hFF, 1'b1, 2};
    vecs[9]  = '{1, 4'd7,  4'h0, 4'd0,  4'h0, 1'b0, 8'd0,  8'h00, 1'b0, 1};
    vecs[10] = '{0, 4'd15, 4'h0, 4'd15, 4'h0, 1'b0, 8'hE1, 8'h00, 1'b0, 4};
    vecs[11] = '{2, 4'd6,  4'h0, 4'd5,  4'h0, 1'b0, 8'd30, 8'h00, 1'b0, 3};
    vecs[12] = '{0, 4'd5,  4'h0, 4'd0,  4'h2, 1'b0, 8'd0,  8'hFE, 1'b0, 4};

    #12;
    chk("reset_busy", 0, busy_w[0], 0);
    chk("reset_done", 0, done_w[0], 0);
    chk("reset_product", 0, prod_w[0], 0);
    chk("reset_product_t", 0, prod_t_w[0], 0);
    @(negedge clk); rst = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start = 1'b1; start_t = vecs[i].st;
      a = vecs[i].a; at = vecs[i].at; b = vecs[i].b; bt = vecs[i].bt;
      @(posedge clk); #1;
      start = 1'b0; start_t = 1'b0;
      wait_done(vecs[i].sel, k, bc);
      $display("vec %0d dut%0d A=%0d At=%h B=%0d Bt=%h st=%0b -> P=%h Pt=%h dt=%0b iters=%0d",
               i, vecs[i].sel, vecs[i].a, vecs[i].at, vecs[i].b, vecs[i].bt, vecs[i].st,
               prod_w[vecs[i].sel], prod_t_w[vecs[i].sel], done_t_w[vecs[i].sel], k);
      chk("latency", vecs[i].sel, k, vecs[i].lat);
      chk("busy_cycles", vecs[i].sel, bc, vecs[i].lat);
      chk("product", vecs[i].sel, prod_w[vecs[i].sel], vecs[i].p);
      chk("product_t", vecs[i].sel, prod_t_w[vecs[i].sel], vecs[i].pt);
      chk("done_t", vecs[i].sel, done_t_w[vecs[i].sel], vecs[i].dt);
      @(posedge clk); #1;
      chk("done_pulse_one_cycle", vecs[i].sel, done_w[vecs[i].sel], 0);
      chk("product_hold", vecs[i].sel, prod_w[vecs[i].sel], vecs[i].p);
      idle_cycles(6);
    end

    // Back-to-back: start held high; operand changes during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; a = 4'd2; b = 4'd3; at = '0; bt = '0;
    @(posedge clk); #1;
    a = 4'd9; b = 4'd9;
    wait_done(0, k, bc);
    $display("b2b first: P=%h iters=%0d", prod_w[0], k);
    chk("b2b1_latency", 0, k, 4);
    chk("b2b1_product", 0, prod_w[0], 8'd6);
    a = 4'd4; b = 4'd5;
    @(posedge clk); #1;
    chk("b2b_restart_busy", 0, busy_w[0], 1);
    chk("b2b_restart_done", 0, done_w[0], 0);
    start = 1'b0;
    wait_done(0, k2, bc2);
    $display("b2b second: P=%h iters=%0d", prod_w[0], k2);
    chk("b2b2_latency", 0, k2, 4);
    chk("b2b2_product", 0, prod_w[0], 8'd20);
    idle_cycles(6);

    // Load nonzero held outputs, then reset two cycles into the next RUN.
    @(negedge clk);
    start = 1'b1; start_t = 1'b1; a = 4'd3; b = 4'd5;
    @(posedge clk); #1;
    start = 1'b0; start_t = 1'b0;
    wait_done(0, k, bc);
    chk("pre_rst_product", 0, prod_w[0], 8'd15);
    chk("pre_rst_done_t", 0, done_t_w[0], 1);
    idle_cycles(3);
    @(negedge clk);
    start = 1'b1; a = 4'd13; b = 4'd11;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_run_busy", 0, busy_w[0], 1);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-run: busy=%0b done=%0b P=%h Pt=%h dt=%0b",
             busy_w[0], done_w[0], prod_w[0], prod_t_w[0], done_t_w[0]);
    chk("async_rst_busy", 0, busy_w[0], 0);
    chk("async_rst_done", 0, done_w[0], 0);
    chk("async_rst_product", 0, prod_w[0], 0);
    chk("async_rst_product_t", 0, prod_t_w[0], 0);
    chk("async_rst_done_t", 0, done_t_w[0], 0);
    @(negedge clk); rst = 1'b0;
    idle_cycles(5); #1;
    chk("post_rst_idle_busy", 0, busy_w[0], 0);
    chk("post_rst_idle_done", 0, done_w[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
